pipelined_cla_addsub: RTL and testbench
=======================================

Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-look-ahead adder/subtractor with valid/ready handshakes on both sides.
- Operands are split into GW-bit lookahead groups. Each group is resolved in one pipeline stage with full intra-group lookahead, so there is no ripple inside a group.
- Generalises the team's 4-bit combinational CLA to arbitrary width, adds a subtract mode and status flags, and runs at one result per cycle.
- Sits in the datapath between operand-issue logic and result consumers that may stall.

Parameters:
- WIDTH, 16: operand/result width in bits. Must be a multiple of GW; otherwise elaboration fails.
- GW, 4: lookahead group width in bits. Legal range 1..8.
- S (localparam), WIDTH/GW: number of pipeline stages, which is also the latency.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in. Used in add mode only.
- sub  in  1  0 = A+B+cin, 1 = A-B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out. In sub mode, 1 = no borrow.
- ovf  out  1  signed overflow
- zero  out  1  sum == 0

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. While rst_n=0, all stage valid bits clear. out_valid=0, sum=0, cout=0, ovf=0, zero=0. in_ready=1 once rst_n deasserts.
- Operand prep at acceptance: b_eff = sub ? ~b : b. c0 = sub ? 1 : cin.
- Acceptance condition: a transfer occurs when in_valid & in_ready at a rising edge. The stage-0 register captures a, b_eff, c0 and the group-0 result.
- Stage k, for k = 0..S-1, handles group k:
  - g_i = a_i & b_i, p_i = a_i ^ b_i.
  - Each carry c_{i+1} is the fully expanded lookahead sum-of-products of g/p and the group carry-in.
  - sum_i = p_i ^ c_i.
  - The stage registers its sum bits, its group carry-out, and the carry into the MSB (last stage only). It carries the remaining operand bits forward; already-consumed operand bits may be dropped.
- Output register: the last stage register drives sum, cout, ovf and zero.
  - cout = carry out of bit WIDTH-1.
  - ovf = c_{WIDTH} ^ c_{WIDTH-1}.
  - zero = (sum == 0). It is registered with the last stage, not decoded from the output port.
- Latency: an operand accepted at edge t has out_valid=1 after edge t+S-1, i.e. visible S cycles after the acceptance cycle. The exact count is S; the bench checks it exactly.
- Throughput: 1 transfer/cycle with no backpressure. Results leave in acceptance order; there is no reordering.
- Stage advance: stage k loads from k-1 when stage k is empty or stage k is advancing. The last stage advances when out_ready=1.
- in_ready: in_ready = !v0 | advance0, combinational from downstream state. It never depends on in_valid.
- Backpressure: with out_valid=1 and out_ready=0, the output holds sum/cout/ovf/zero stable and out_valid stays 1. Upstream stages fill any bubbles, then stall. in_ready falls only when all S stages are full and the output is stalled.
- Simultaneous accept and drain when full: a transfer in and a transfer out in the same cycle are both legal, and occupancy stays S.
- Empty stages: registers of empty stages may hold stale data, but out_valid must be 0.
- Reset mid-operation: all in-flight operations are discarded immediately. out_valid drops asynchronously and nothing is emitted after release.
- GW=WIDTH: degenerates to a single-stage registered CLA with latency 1.

Test Plan (WIDTH=16, GW=4, S=4):
- Add with wrap: a=0xFFFF, b=0x0001, cin=0, sub=0 -> 4 cycles later sum=0x0000, cout=1, zero=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1, cout=0, zero=0. Also a=0x1234, b=0x0FCB, cin=1 -> sum=0x2200, cout=0.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (must be ignored) -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1, cout=1.
- Streaming: 100 random back-to-back transfers with out_ready=1 -> one result per cycle, in order, each matching a reference model, first result exactly 4 cycles after first accept.
- Backpressure: fill the pipe, hold out_ready=0 for 6 cycles -> the output holds stable, in_ready=0 after 4 accepted items plus the held output, and no loss or duplication after release. Also check simultaneous accept/drain when full.
- Reset: assert rst_n=0 mid-stream for 1 cycle -> out_valid=0 and sum=0 immediately, no stale results after release, and correct results for new operands.

Source files
------------

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-look-ahead adder/subtractor: one GW-bit lookahead group per stage,
// valid/ready on both sides, one result per cycle, latency WIDTH/GW.

module cla_group #(
    parameter int GW = 4
) (
    input  logic [GW-1:0] a_i,
    input  logic [GW-1:0] b_i,
    input  logic          c_i,
    output logic [GW-1:0] s_o,
    output logic          co_o
);
    logic [GW-1:0] g, p;
    logic [GW:0]   c;
    logic          t, pp;

    // Each carry is the flat sum-of-products of g/p and c_i; no ripple through c[].
    always_comb begin
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        c  = '0;
        t  = 1'b0;
        pp = 1'b0;
        c[0] = c_i;
        for (int i = 0; i < GW; i++) begin
            t  = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                t  = t | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = t | (pp & c_i);
        end
    end

    assign s_o  = p ^ c[GW-1:0];
    assign co_o = c[GW];
endmodule

module pipelined_cla_addsub #(
    parameter int WIDTH = 16,
    parameter int GW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int S = WIDTH / GW;

    if (GW < 1 || GW > 8 || (WIDTH % GW) != 0) begin : g_bad_params
        $error("pipelined_cla_addsub: WIDTH must be a multiple of GW, GW in 1..8");
    end

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [S-1:0]     v_q, vin, en, ld;

    assign b_eff = sub ? ~b : b;
    assign c0    = sub | cin;

    // A stage may load if any stage at or after it is empty, or the output drains.
    always_comb begin
        vin = '0;
        en  = '0;
        vin[0] = in_valid;
        for (int k = 1; k < S; k++) vin[k] = v_q[k-1];
        en[S-1] = out_ready | ~v_q[S-1];
        for (int k = S - 2; k >= 0; k--) en[k] = en[k+1] | ~v_q[k];
        ld = en & vin;
    end

    assign in_ready  = en[0];
    assign out_valid = v_q[S-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            for (int k = 0; k < S; k++)
                if (en[k]) v_q[k] <= vin[k];
        end
    end

    for (genvar k = 0; k < S; k++) begin : g_st
        localparam int IW = WIDTH - k * GW;
        logic [IW-1:0]         ra, rb;
        logic                  ci, co;
        logic [GW-1:0]         gs;
        logic [(k+1)*GW-1:0]   s_d;

        if (k == 0) begin : g_in
            assign ra  = a;
            assign rb  = b_eff;
            assign ci  = c0;
            assign s_d = gs;
        end else begin : g_in
            assign ra  = g_st[k-1].g_reg.a_q;
            assign rb  = g_st[k-1].g_reg.b_q;
            assign ci  = g_st[k-1].g_reg.c_q;
            assign s_d = {gs, g_st[k-1].g_reg.s_q};
        end

        cla_group #(.GW(GW)) u_grp (
            .a_i (ra[GW-1:0]),
            .b_i (rb[GW-1:0]),
            .c_i (ci),
            .s_o (gs),
            .co_o(co)
        );

        // Only the not-yet-consumed operand bits travel forward.
        if (k < S - 1) begin : g_reg
            logic [IW-GW-1:0]    a_q, b_q;
            logic [(k+1)*GW-1:0] s_q;
            logic                c_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                end else if (ld[k]) begin
                    a_q <= ra[IW-1:GW];
                    b_q <= rb[IW-1:GW];
                    s_q <= s_d;
                    c_q <= co;
                end
            end
        end
    end

    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, zero_q;
    logic             cm_last;

    // Carry into the MSB recovered from its sum bit: c = a ^ b ^ s.
    assign cm_last = g_st[S-1].ra[GW-1] ^ g_st[S-1].rb[GW-1] ^ g_st[S-1].gs[GW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (ld[S-1]) begin
            sum_q  <= g_st[S-1].s_d;
            cout_q <= g_st[S-1].co;
            ovf_q  <= g_st[S-1].co ^ cm_last;
            zero_q <= ~|g_st[S-1].s_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench for pipelined_cla_addsub (WIDTH=16, GW=4): directed table,
// random streaming, backpressure, mid-stream reset, random stress vs. an arithmetic model.

module tb_pipelined_cla_addsub;
    localparam int W = 16;
    localparam int G = 4;
    localparam int S = W / G;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
    logic [W-1:0] a, b, sum;

    always #5 clk = ~clk;

    pipelined_cla_addsub #(.WIDTH(W), .GW(G)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] s;
        logic        co, ov, z;
    } vec_t;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, acc_cyc = 0, pop_cyc = 0, first_pop = 0, n_pop = 0;
    logic [18:0] sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // {sum, cout, ovf, zero} from plain integer arithmetic.
    function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
        int          sx, sy, r;
        logic [16:0] u;
        logic [15:0] res;
        logic        co;
        sx = $signed(x);
        sy = $signed(y);
        if (s) begin
            res = x - y;
            co  = (x >= y);
            r   = sx - sy;
        end else begin
            u   = {1'b0, x} + {1'b0, y} + {16'd0, c};
            res = u[15:0];
            co  = u[16];
            r   = sx + sy + int'(c);
        end
        return {res, co, (r > 32767) || (r < -32768), res == 16'd0};
    endfunction

    // One clock: drive inputs, score the output transfer and record the input transfer.
    task automatic cycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                         input logic ic, input logic is, input logic ordy,
                         input logic [18:0] exp, output logic acc);
        in_valid = iv; a = ia; b = ib; cin = ic; sub = is; out_ready = ordy;
        #1;
        acc = in_valid & in_ready;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("spurious_out_valid", out_valid, 0);
            else begin
                chk("result", {sum, cout, ovf, zero}, sb.pop_front());
                if (n_pop == 0) first_pop = cyc;
                pop_cyc = cyc;
                n_pop++;
            end
        end
        if (acc) begin
            sb.push_back(exp);
            acc_cyc = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        logic acc;
        int   k = 0;
        while (sb.size() > 0 && k < 60) begin
            cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 19'd0, acc);
            k++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic send_rand(input logic ordy, output logic acc);
        logic [15:0] x, y;
        logic        c, s;
        x = 16'($urandom); y = 16'($urandom);
        c = 1'($urandom); s = 1'($urandom);
        cycle(1'b1, x, y, c, s, ordy, model(x, y, c, s), acc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[8];
        logic        acc;
        logic [18:0] held;
        int          first_acc, sent, k;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{16'h1234, 16'h0FCB, 1'b1, 1'b0, 16'h2200, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("reset_outputs", {out_valid, sum, cout, ovf, zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("in_ready_after_reset", in_ready, 1);
        @(negedge clk);

        // Directed vectors, one at a time, exact latency.
        foreach (tbl[i]) begin
            cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b1,
                  {tbl[i].s, tbl[i].co, tbl[i].ov, tbl[i].z}, acc);
            chk("tbl_accept", acc, 1);
            drain();
            chk("tbl_latency", pop_cyc - acc_cyc, S);
        end

        // Back-to-back streaming with the consumer always ready.
        n_pop = 0; first_acc = -1;
        for (int i = 0; i < 100; i++) begin
            k = 0;
            do begin
                send_rand(1'b1, acc);
                k++;
            end while (!acc && k < 10);
            if (first_acc < 0) first_acc = acc_cyc;
        end
        drain();
        chk("stream_count", n_pop, 100);
        chk("stream_first_latency", first_pop - first_acc, S);
        chk("stream_accept_span", acc_cyc - first_acc, 99);
        chk("stream_output_span", pop_cyc - first_pop, 99);

        // Backpressure: fill, hold, then simultaneous accept/drain while full.
        n_pop = 0; sent = 0;
        for (int i = 0; i < 8; i++) begin
            send_rand(1'b0, acc);
            if (acc) sent++;
        end
        chk("bp_accepted", sent, S);
        chk("bp_in_ready_low", in_ready, 0);
        held = sb[0];
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 19'd0, acc);
            chk("bp_hold", {out_valid, sum, cout, ovf, zero}, {1'b1, held});
        end
        send_rand(1'b1, acc);
        chk("bp_accept_and_drain", acc, 1);
        out_ready = 1'b0;
        #1 chk("bp_still_full", {in_ready, out_valid}, 2'b01);
        drain();
        chk("bp_count", n_pop, S + 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 19'd0, acc);
            chk("bp_no_dup", out_valid, 0);
        end

        // Reset mid-stream.
        for (int i = 0; i < 6; i++) send_rand(1'b1, acc);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {out_valid, sum, cout, ovf, zero}, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 19'd0, acc);
            chk("rst_no_stale", out_valid, 0);
        end
        n_pop = 0;
        for (int i = 0; i < 10; i++) send_rand(1'b1, acc);
        drain();
        chk("rst_new_count", n_pop, 10);

        // Random valid/ready stress.
        n_pop = 0; sent = 0; k = 0;
        while (sent < 150 && k < 3000) begin
            logic [15:0] x, y;
            logic        c, s;
            x = 16'($urandom); y = 16'($urandom);
            c = 1'($urandom); s = 1'($urandom);
            cycle($urandom_range(0, 9) < 7, x, y, c, s, $urandom_range(0, 9) < 6,
                  model(x, y, c, s), acc);
            if (acc) sent++;
            k++;
        end
        drain();
        chk("stress_count", n_pop, 150);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
